// File: rtl/nco_pkg.sv
// nco_pkg: shared widths, quarter-turn constant and dither LFSR definition for the NCO.
package nco_pkg;
  localparam int AW_DEF = 32;
  localparam int PW_DEF = 12;
  localparam int QUARTER_TURN = 1 << (PW_DEF - 2);
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // x^16 + x^14 + x^13 + x^11 + 1 as Fibonacci taps on bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
endpackage

// File: rtl/nco_dither_lfsr.sv
// nco_dither_lfsr: 16-bit Fibonacci LFSR advancing once per clock enable, used as phase dither.
module nco_dither_lfsr
  import nco_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_ce,
  output logic [15:0] o_lfsr
);
  logic [15:0] lfsr_q, lfsr_d;
  always_comb lfsr_d = i_ce ? {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)} : lfsr_q;
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) lfsr_q <= LFSR_SEED;
    else lfsr_q <= lfsr_d;
  assign o_lfsr = lfsr_q;
endmodule

// File: rtl/nco_phase_accumulator.sv
// nco_phase_accumulator: phase accumulator with shadowed config, truncated I/Q phases and wrap pulse.
// Define PHASE_DITHER_EN to add LFSR dither below the truncation point.
module nco_phase_accumulator
  import nco_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int PW = PW_DEF
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_ce,
  input  logic          i_cfg_valid,
  output logic          o_cfg_ready,
  input  logic [AW-1:0] i_cfg_freq,
  input  logic [AW-1:0] i_cfg_phase,
  input  logic          i_cfg_sync,
  output logic [PW-1:0] o_phase_i,
  output logic [PW-1:0] o_phase_q,
  output logic          o_wrap
);
  localparam logic [PW-1:0] QTR = PW'(1 << (PW - 2));
  logic [AW-1:0] acc_q, acc_d, freq_q, freq_d, off_q, off_d;
  logic [AW-1:0] sh_freq_q, sh_phase_q, dither, phase_sum;
  logic          sh_sync_q, sh_full_q, sh_full_d, wrap_q, wrap_d;
  logic [PW-1:0] pi_q, pi_d, pq_q, pq_d;
  logic [AW:0]   sum;
  logic          accept, apply, sync_apply;
`ifdef PHASE_DITHER_EN
  localparam logic [15:0] DMASK = (AW - PW >= 16) ? 16'hFFFF : 16'((32'd1 << (AW - PW)) - 32'd1);
  logic [15:0] lfsr;
  nco_dither_lfsr u_lfsr (
    .i_clk(i_clk),
    .i_reset_n(i_reset_n),
    .i_ce(i_ce),
    .o_lfsr(lfsr)
  );
  assign dither = AW'(lfsr & DMASK);
`else
  assign dither = '0;
`endif
  always_comb begin
    accept     = i_cfg_valid & ~sh_full_q;
    apply      = i_ce & sh_full_q;
    sync_apply = apply & sh_sync_q;
    sum        = {1'b0, acc_q} + {1'b0, freq_q};
    phase_sum  = acc_q + off_q + dither;
    acc_d      = sync_apply ? '0 : i_ce ? sum[AW-1:0] : acc_q;
    freq_d     = apply ? sh_freq_q : freq_q;
    off_d      = apply ? sh_phase_q : off_q;
    sh_full_d  = accept | (sh_full_q & ~apply);
    wrap_d     = i_ce & sum[AW] & ~sync_apply;
    pi_d       = i_ce ? phase_sum[AW-1 -: PW] : pi_q;
    pq_d       = pi_d + QTR;
  end
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      acc_q     <= '0;
      freq_q    <= '0;
      off_q     <= '0;
      sh_full_q <= 1'b0;
      wrap_q    <= 1'b0;
      pi_q      <= '0;
      pq_q      <= QTR;
    end else begin
      acc_q     <= acc_d;
      freq_q    <= freq_d;
      off_q     <= off_d;
      sh_full_q <= sh_full_d;
      wrap_q    <= wrap_d;
      pi_q      <= pi_d;
      pq_q      <= pq_d;
    end
  // Shadow payload is only meaningful while sh_full_q is set.
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      sh_freq_q  <= '0;
      sh_phase_q <= '0;
      sh_sync_q  <= 1'b0;
    end else if (accept) begin
      sh_freq_q  <= i_cfg_freq;
      sh_phase_q <= i_cfg_phase;
      sh_sync_q  <= i_cfg_sync;
    end
  assign o_cfg_ready = ~sh_full_q;
  assign o_phase_i   = pi_q;
  assign o_phase_q   = pq_q;
  assign o_wrap      = wrap_q;
endmodule

// File: tb/tb_nco_phase_accumulator.sv
// tb_nco_phase_accumulator: directed vectors, expected outputs queued per cycle and checked by a monitor.
module tb_nco_phase_accumulator;
  logic clk = 0, rst_n = 0, ce = 0, valid = 0, sync = 0;
  logic [31:0] freq = '0, phase = '0;
  logic rdy, wrap;
  logic [11:0] pi, pq;
  int total = 0, bad = 0;
  typedef struct packed {
    logic [11:0] pi;
    logic [11:0] pq;
    logic        w;
    logic        r;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  always #5 clk = ~clk;
  nco_phase_accumulator #(.AW(32), .PW(12)) dut (
    .i_clk(clk),
    .i_reset_n(rst_n),
    .i_ce(ce),
    .i_cfg_valid(valid),
    .o_cfg_ready(rdy),
    .i_cfg_freq(freq),
    .i_cfg_phase(phase),
    .i_cfg_sync(sync),
    .o_phase_i(pi),
    .o_phase_q(pq),
    .o_wrap(wrap)
  );
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    total++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", n, a, x, $time);
    end
  endtask
  task automatic step(input logic c, input logic v, input logic [31:0] f, input logic [31:0] p,
                      input logic s, input logic [11:0] ei, input logic ew, input logic er);
    @(negedge clk);
    ce = c; valid = v; freq = f; phase = p; sync = s;
    sb.push_back('{ei, ei + 12'h400, ew, er});
  endtask
  task automatic chk_reset(input string n);
    chk({n, "_pi"}, 32'(pi), 32'h000);
    chk({n, "_pq"}, 32'(pq), 32'h400);
    chk({n, "_rdy"}, 32'(rdy), 32'h1);
    chk({n, "_wrap"}, 32'(wrap), 32'h0);
  endtask
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("phase_i", 32'(pi), 32'(e.pi));
      chk("phase_q", 32'(pq), 32'(e.pq));
      chk("wrap", 32'(wrap), 32'(e.w));
      chk("ready", 32'(rdy), 32'(e.r));
    end
  end
  initial begin
    repeat (2) @(negedge clk);
    chk_reset("reset");
    rst_n = 1;
    // ramp of 1/16 turn per ce, wrap on 16th sample, held through one ce=0 cycle
    step(1, 1, 32'h1000_0000, 0, 0, 12'h000, 0, 0);
    step(1, 0, 0, 0, 0, 12'h000, 0, 1);
    for (int k = 1; k <= 18; k++) begin
      step(1, 0, 0, 0, 0, 12'((k - 1) * 256), k == 16, 1);
      if (k == 16) step(0, 0, 0, 0, 0, 12'hF00, 0, 1);
    end
    // freq=0, quarter-turn offset, synced accumulator
    step(1, 1, 0, 32'h4000_0000, 1, 12'h200, 0, 0);
    step(1, 0, 0, 0, 0, 12'h300, 0, 1);
    repeat (4) step(1, 0, 0, 0, 0, 12'h400, 0, 1);
    // accept with ce low, second word ignored until ready returns
    step(0, 1, 32'h0800_0000, 0, 0, 12'h400, 0, 0);
    repeat (4) step(0, 1, 32'h2000_0000, 0, 0, 12'h400, 0, 0);
    step(1, 1, 32'h2000_0000, 0, 0, 12'h400, 0, 1);
    step(1, 1, 32'h2000_0000, 0, 0, 12'h000, 0, 0);
    step(1, 0, 0, 0, 0, 12'h080, 0, 1);
    step(1, 0, 0, 0, 0, 12'h100, 0, 1);
    step(1, 0, 0, 0, 0, 12'h300, 0, 1);
    step(1, 0, 0, 0, 0, 12'h500, 0, 1);
    step(1, 0, 0, 0, 0, 12'h700, 0, 1);
    step(1, 0, 0, 0, 0, 12'h900, 0, 1);
    step(1, 0, 0, 0, 0, 12'hB00, 0, 1);
    step(1, 0, 0, 0, 0, 12'hD00, 0, 1);
    // sync apply on a carrying cycle: wrap suppressed, restart at offset
    step(0, 1, 32'h2000_0000, 32'h0800_0000, 1, 12'hD00, 0, 0);
    step(1, 0, 0, 0, 0, 12'hF00, 0, 1);
    step(1, 0, 0, 0, 0, 12'h080, 0, 1);
    step(1, 0, 0, 0, 0, 12'h280, 0, 1);
    // reset with a pending shadow word discards it
    step(0, 1, 32'h1000_0000, 32'h4000_0000, 0, 12'h280, 0, 0);
    @(negedge clk);
    valid = 0;
    rst_n = 0;
    #1;
    chk_reset("async_reset");
    @(negedge clk);
    rst_n = 1;
    repeat (3) step(1, 0, 0, 0, 0, 12'h000, 0, 1);
    // half-turn increment alternates phase and wraps every other ce
    step(1, 1, 32'h8000_0000, 0, 0, 12'h000, 0, 0);
    step(1, 0, 0, 0, 0, 12'h000, 0, 1);
    step(1, 0, 0, 0, 0, 12'h000, 0, 1);
    step(1, 0, 0, 0, 0, 12'h800, 1, 1);
    step(1, 0, 0, 0, 0, 12'h000, 0, 1);
    step(1, 0, 0, 0, 0, 12'h800, 1, 1);
    step(0, 0, 0, 0, 0, 12'h800, 0, 1);
    repeat (3) @(negedge clk);
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
